// File: rtl/mux_key_table_pkg.sv
// Shared constants and helpers for the programmable key->value lookup table.
package mux_key_table_pkg;

  localparam int MATCH_PRIORITY = 0;
  localparam int MATCH_OR       = 1;

  typedef enum logic {
    MODE_PRIORITY = 1'b0,
    MODE_OR       = 1'b1
  } match_mode_e;

  function automatic match_mode_e to_mode(input int match_mode);
    return (match_mode == MATCH_OR) ? MODE_OR : MODE_PRIORITY;
  endfunction

endpackage

// File: rtl/mux_key_match.sv
// Combinational key match across all entries: priority select or OR-merge of
// matching entries' data, DEFAULT when nothing matches.
module mux_key_match
  import mux_key_table_pkg::*;
#(
  parameter int                  NR_KEY   = 4,
  parameter int                  KEY_LEN  = 2,
  parameter int                  DATA_LEN = 1,
  parameter logic [DATA_LEN-1:0] DEFAULT  = '0
) (
  input  logic [KEY_LEN-1:0]               key,
  input  logic [NR_KEY-1:0]                vld,
  input  logic [NR_KEY-1:0][KEY_LEN-1:0]   keys,
  input  logic [NR_KEY-1:0][DATA_LEN-1:0]  datas,
  input  logic                             mode,
  output logic                             hit,
  output logic [DATA_LEN-1:0]              data
);

  logic [DATA_LEN-1:0] acc;

  // NOTE: every variable gets a default before the loop so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    hit = 1'b0;
    acc = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (vld[i] && (keys[i] == key)) begin
        if (mode == MODE_OR) begin
          acc = acc | datas[i];
        end else if (!hit) begin
          acc = datas[i];
        end
        hit = 1'b1;
      end
    end
    data = hit ? acc : DEFAULT;
  end

endmodule

// File: rtl/mux_key_table.sv
// Runtime-programmable key->value table with a one-stage registered
// valid/ready lookup pipeline.
module mux_key_table
  import mux_key_table_pkg::*;
#(
  parameter int                  NR_KEY     = 4,
  parameter int                  KEY_LEN    = 2,
  parameter int                  DATA_LEN   = 1,
  parameter int                  MATCH_MODE = MATCH_PRIORITY,
  parameter logic [DATA_LEN-1:0] DEFAULT    = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(NR_KEY)-1:0]   wr_idx,
  input  logic [KEY_LEN-1:0]          wr_key,
  input  logic [DATA_LEN-1:0]         wr_data,
  input  logic                        clr,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [KEY_LEN-1:0]          req_key,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        resp_hit,
  output logic [DATA_LEN-1:0]         resp_data
);

  localparam match_mode_e MODE = to_mode(MATCH_MODE);

  logic [NR_KEY-1:0]               vld;
  logic [NR_KEY-1:0][KEY_LEN-1:0]  keys;
  logic [NR_KEY-1:0][DATA_LEN-1:0] datas;
  logic                            idx_ok;
  logic                            accept;
  logic                            lkp_hit;
  logic [DATA_LEN-1:0]             lkp_data;

  assign idx_ok    = int'(wr_idx) < NR_KEY;
  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;

  // NOTE: non-blocking assignments here, so the later write wins over the
  // clear in the same edge and the lookup below sees pre-edge contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      if (clr) begin
        vld <= '0;
      end
      if (wr_en && idx_ok) begin
        vld[wr_idx] <= 1'b1;
      end
    end
  end

  // NOTE: key/data storage has no reset; an entry is meaningless until its
  // vld bit is set, and leaving it unreset keeps it plain flops/RAM.
  always_ff @(posedge clk) begin
    if (wr_en && idx_ok) begin
      keys[wr_idx]  <= wr_key;
      datas[wr_idx] <= wr_data;
    end
  end

  mux_key_match #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN),
    .DEFAULT  (DEFAULT)
  ) u_match (
    .key   (req_key),
    .vld   (vld),
    .keys  (keys),
    .datas (datas),
    .mode  (MODE),
    .hit   (lkp_hit),
    .data  (lkp_data)
  );

  // A stalled response holds its captured value even if the table changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_data  <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_hit   <= lkp_hit;
      resp_data  <= lkp_data;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_key_table.sv
// Self-checking bench: a priority DUT and an OR-merge DUT share stimulus and
// are checked every cycle against a queue-based table model plus literals.
module tb_mux_key_table;

  localparam logic [7:0] DEF_P = 8'h5A;
  localparam logic [7:0] DEF_O = 8'hC3;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_key;
  logic [7:0] wr_data;
  logic       clr;
  logic       req_valid;
  logic [3:0] req_key;
  logic       resp_ready;

  logic       p_req_ready, p_resp_valid, p_resp_hit;
  logic [7:0] p_resp_data;
  logic       o_req_ready, o_resp_valid, o_resp_hit;
  logic [7:0] o_resp_data;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mux_key_table #(
    .NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .MATCH_MODE(0), .DEFAULT(DEF_P)
  ) u_pri (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .req_valid(req_valid), .req_ready(p_req_ready),
    .req_key(req_key), .resp_valid(p_resp_valid), .resp_ready(resp_ready),
    .resp_hit(p_resp_hit), .resp_data(p_resp_data)
  );

  mux_key_table #(
    .NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .MATCH_MODE(1), .DEFAULT(DEF_O)
  ) u_or (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .req_valid(req_valid), .req_ready(o_req_ready),
    .req_key(req_key), .resp_valid(o_resp_valid), .resp_ready(resp_ready),
    .resp_hit(o_resp_hit), .resp_data(o_resp_data)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  bit         m_vld[4];
  logic [3:0] m_key[4];
  logic [7:0] m_dat[4];
  logic       m_valid, m_hit;
  logic [7:0] m_dp, m_do;
  bit         started = 1'b0;

  always @(posedge clk) begin
    logic [7:0] hits[$];
    started <= 1'b1;
    if (rst) begin
      m_valid <= 1'b0;
      m_hit   <= 1'b0;
      m_dp    <= 8'h00;
      m_do    <= 8'h00;
      for (int i = 0; i < 4; i++) m_vld[i] <= 1'b0;
    end else begin
      if (req_valid && (!m_valid || resp_ready)) begin
        hits = {};
        for (int i = 0; i < 4; i++)
          if (m_vld[i] && m_key[i] == req_key) hits.push_back(m_dat[i]);
        m_valid <= 1'b1;
        if (hits.size() > 0) begin
          m_hit <= 1'b1;
          m_dp  <= hits[0];
          m_do  <= hits.or();
        end else begin
          m_hit <= 1'b0;
          m_dp  <= DEF_P;
          m_do  <= DEF_O;
        end
      end else if (resp_ready) begin
        m_valid <= 1'b0;
      end
      if (clr) for (int i = 0; i < 4; i++) m_vld[i] <= 1'b0;
      if (wr_en && int'(wr_idx) < 4) begin
        m_vld[wr_idx] <= 1'b1;
        m_key[wr_idx] <= wr_key;
        m_dat[wr_idx] <= wr_data;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("cmp.pri.req_ready",  32'(p_req_ready),  32'(!m_valid || resp_ready));
      check("cmp.pri.resp_valid", 32'(p_resp_valid), 32'(m_valid));
      check("cmp.pri.resp_hit",   32'(p_resp_hit),   32'(m_hit));
      check("cmp.pri.resp_data",  32'(p_resp_data),  32'(m_dp));
      check("cmp.or.req_ready",   32'(o_req_ready),  32'(!m_valid || resp_ready));
      check("cmp.or.resp_valid",  32'(o_resp_valid), 32'(m_valid));
      check("cmp.or.resp_hit",    32'(o_resp_hit),   32'(m_hit));
      check("cmp.or.resp_data",   32'(o_resp_data),  32'(m_do));
    end
  end

  // ---------------- stimulus helpers (start and end at posedge+1) ----------------
  task automatic wr(input logic [1:0] idx, input logic [3:0] k, input logic [7:0] d);
    wr_en = 1'b1; wr_idx = idx; wr_key = k; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic lookup(input logic [3:0] k);
    req_valid = 1'b1; req_key = k;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_resp(input string nm, input logic hit, input logic [7:0] dp, input logic [7:0] dor);
    check({nm, ".valid.pri"}, 32'(p_resp_valid), 32'(1));
    check({nm, ".valid.or"},  32'(o_resp_valid), 32'(1));
    check({nm, ".ready.pri"}, 32'(p_req_ready),  32'(1));
    check({nm, ".hit.pri"},   32'(p_resp_hit),   32'(hit));
    check({nm, ".hit.or"},    32'(o_resp_hit),   32'(hit));
    check({nm, ".data.pri"},  32'(p_resp_data),  32'(dp));
    check({nm, ".data.or"},   32'(o_resp_data),  32'(dor));
  endtask

  task automatic expect_resp(input string nm, input logic hit, input logic [7:0] dp, input logic [7:0] dor);
    @(negedge clk);
    check_resp(nm, hit, dp, dor);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_reset(input string nm);
    check({nm, ".valid"}, 32'(p_resp_valid), 32'(0));
    check({nm, ".hit"},   32'(p_resp_hit),   32'(0));
    check({nm, ".data"},  32'(p_resp_data),  32'(0));
    check({nm, ".ready"}, 32'(p_req_ready),  32'(1));
    check({nm, ".or.data"}, 32'(o_resp_data), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0;
    clr = 1'b0; req_valid = 1'b0; req_key = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Lookup on an empty table misses with DEFAULT.
    lookup(4'd2);
    expect_resp("empty_k2", 1'b0, DEF_P, DEF_O);

    // 4-entry 2-bit mux image, back-to-back lookups at full throughput.
    wr(2'd0, 4'd1, 8'h01);
    wr(2'd3, 4'd2, 8'h01);
    req_valid = 1'b1; req_key = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) req_key = 4'(k + 1);
      else       req_valid = 1'b0;
      @(negedge clk);
      if (k == 1 || k == 2) check_resp($sformatf("mux_k%0d", k), 1'b1, 8'h01, 8'h01);
      else                  check_resp($sformatf("mux_k%0d", k), 1'b0, DEF_P, DEF_O);
    end
    @(posedge clk); #1;

    // Duplicate keys: priority picks idx1, OR merges both.
    wr(2'd1, 4'd5, 8'h0F);
    wr(2'd2, 4'd5, 8'hF0);
    lookup(4'd5);
    expect_resp("dup_k5", 1'b1, 8'h0F, 8'hFF);

    // Write and lookup in the same cycle: lookup sees the old (empty) table.
    do_clr();
    wr_en = 1'b1; wr_idx = 2'd0; wr_key = 4'd3; wr_data = 8'hAA;
    req_valid = 1'b1; req_key = 4'd3;
    @(posedge clk); #1;
    wr_en = 1'b0; req_valid = 1'b0;
    expect_resp("hazard_miss", 1'b0, DEF_P, DEF_O);
    lookup(4'd3);
    expect_resp("hazard_hit", 1'b1, 8'hAA, 8'hAA);

    // Clear and write in the same cycle: only the written entry survives.
    wr(2'd1, 4'd4, 8'h22);
    wr(2'd3, 4'd6, 8'h33);
    clr = 1'b1;
    wr(2'd2, 4'd7, 8'h11);
    clr = 1'b0;
    lookup(4'd7); expect_resp("clrwr_k7", 1'b1, 8'h11, 8'h11);
    lookup(4'd3); expect_resp("clrwr_k3", 1'b0, DEF_P, DEF_O);
    lookup(4'd4); expect_resp("clrwr_k4", 1'b0, DEF_P, DEF_O);
    lookup(4'd6); expect_resp("clrwr_k6", 1'b0, DEF_P, DEF_O);

    // Backpressure: hold a response for three cycles, write underneath it.
    idle(2);
    resp_ready = 1'b0; req_valid = 1'b1; req_key = 4'd7;
    @(posedge clk); #1;
    req_key = 4'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d.ready.pri", c), 32'(p_req_ready), 32'(0));
      check($sformatf("stall%0d.ready.or", c),  32'(o_req_ready), 32'(0));
      check($sformatf("stall%0d.valid", c),     32'(p_resp_valid), 32'(1));
      check($sformatf("stall%0d.data.pri", c),  32'(p_resp_data), 32'(8'h11));
      check($sformatf("stall%0d.data.or", c),   32'(o_resp_data), 32'(8'h11));
      @(posedge clk); #1;
      if (c == 0) begin
        wr_en = 1'b1; wr_idx = 2'd2; wr_key = 4'd7; wr_data = 8'h99;
      end else begin
        wr_en = 1'b0;
      end
    end
    resp_ready = 1'b1; req_key = 4'd7;
    #1;
    check("release.ready", 32'(p_req_ready), 32'(1));
    check("release.held_data", 32'(p_resp_data), 32'(8'h11));
    @(posedge clk); #1;
    req_valid = 1'b0;
    expect_resp("release_k7", 1'b1, 8'h99, 8'h99);

    // Reset while a response is stalled drops it and empties the table.
    resp_ready = 1'b0;
    lookup(4'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    check_idle_reset("midreset");
    @(posedge clk); #1;
    lookup(4'd7);
    expect_resp("midreset_k7", 1'b0, DEF_P, DEF_O);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
